// File: rtl/addsub_bcd_seq.sv
// Sequential add/subtract unit with an iterative shift-add-3 binary-to-BCD converter.
// Optional build macro: SIGNED_MAG_EN (negative differences are shown as a magnitude with neg=1).
module addsub_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH:0]        result,
  output logic                  neg,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [1:0]            state_dbg
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 2);

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  generate
    if (WIDTH < 2 || WIDTH > 16) begin : g_width_chk
      $error("addsub_bcd_seq: WIDTH must be in 2..16");
    end
    if (pow10(DIGITS) <= ((longint'(1) << (WIDTH + 1)) - 1)) begin : g_digit_chk
      $error("addsub_bcd_seq: DIGITS too small for a (WIDTH+1)-bit value");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    a_r, b_r;
  logic                mode_r;
  logic [WIDTH:0]      raw_r;
  logic                neg_r;
  logic [WIDTH:0]      v_r;
  logic [BW-1:0]       bcd_sr;
  logic [CW-1:0]       cnt;

  logic [WIDTH:0]      raw_calc;
  logic [WIDTH:0]      v_calc;
  logic                neg_calc;
  logic [BW-1:0]       bcd_adj;
  logic [BW+WIDTH:0]   shifted;

  assign state_dbg = state;

  always_comb begin
    raw_calc = '0;
    v_calc   = '0;
    neg_calc = 1'b0;
    bcd_adj  = '0;
    shifted  = '0;
    // Subtracting with one extra bit leaves the borrow in the MSB.
    raw_calc = mode_r ? ({1'b0, a_r} - {1'b0, b_r}) : ({1'b0, a_r} + {1'b0, b_r});
`ifdef SIGNED_MAG_EN
    neg_calc = mode_r & (a_r < b_r);
    if (neg_calc)    v_calc = {1'b0, b_r - a_r};
    else if (mode_r) v_calc = {1'b0, raw_calc[WIDTH-1:0]};
    else             v_calc = raw_calc;
`else
    neg_calc = 1'b0;
    v_calc   = mode_r ? {1'b0, raw_calc[WIDTH-1:0]} : raw_calc;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = (bcd_sr[4*i +: 4] >= 4'd5) ? (bcd_sr[4*i +: 4] + 4'd3)
                                                     : bcd_sr[4*i +: 4];
    end
    shifted = {bcd_adj, v_r} << 1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      neg    <= 1'b0;
      bcd    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      mode_r <= 1'b0;
      raw_r  <= '0;
      neg_r  <= 1'b0;
      v_r    <= '0;
      bcd_sr <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            mode_r <= mode;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          raw_r  <= raw_calc;
          neg_r  <= neg_calc;
          v_r    <= v_calc;
          bcd_sr <= '0;
          cnt    <= CW'(WIDTH + 1);
          state  <= CONV;
        end
        CONV: begin
          bcd_sr <= shifted[BW+WIDTH:WIDTH+1];
          v_r    <= shifted[WIDTH:0];
          cnt    <= cnt - 1'b1;
          // Last shift: publish directly from the shifted value.
          if (cnt == CW'(1)) begin
            bcd    <= shifted[BW+WIDTH:WIDTH+1];
            result <= raw_r;
            neg    <= neg_r;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_bcd_seq.sv
// Bench for addsub_bcd_seq: randomized and directed operations checked against an arithmetic model
// through an expected-value queue, plus reset-abort, held-start and a WIDTH=4 instance.
module tb_addsub_bcd_seq;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int EW = (W + 1) + 1 + 4 * D;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           rst_n;
  logic           start, mode;
  logic [W-1:0]   a, b;
  logic           busy, done, neg;
  logic [W:0]     result;
  logic [4*D-1:0] bcd;
  logic [1:0]     state_dbg;

  logic           start4, mode4;
  logic [3:0]     a4, b4;
  logic           busy4, done4, neg4;
  logic [4:0]     result4;
  logic [7:0]     bcd4;
  logic [1:0]     state4;

  addsub_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .CLOCK_50(clk), .RST_N(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .neg(neg), .bcd(bcd), .state_dbg(state_dbg)
  );

  addsub_bcd_seq #(.WIDTH(4), .DIGITS(2)) dut4 (
    .CLOCK_50(clk), .RST_N(rst_n), .start(start4), .mode(mode4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .neg(neg4), .bcd(bcd4), .state_dbg(state4)
  );

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int done_exp = 0;
  logic [EW-1:0] exp_q[$];
  int            lat_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic, decimal digits by repeated division.
  function automatic logic [EW-1:0] model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
    int ai, bi, raw, val;
    logic ng;
    logic [W:0] r;
    logic [4*D-1:0] dg;
    ai  = int'(x);
    bi  = int'(y);
    raw = m ? ai - bi : ai + bi;
    ng  = 1'b0;
`ifdef SIGNED_MAG_EN
    if (m && ai < bi) begin
      ng  = 1'b1;
      val = bi - ai;
    end else begin
      val = m ? ai - bi : raw;
    end
`else
    val = m ? ((ai - bi) & 32'hFF) : raw;
`endif
    r  = raw[W:0];
    dg = '0;
    for (int k = 0; k < D; k++) begin
      dg[4*k +: 4] = 4'(val % 10);
      val = val / 10;
    end
    return {r, ng, dg};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        logic [EW-1:0] e;
        int l;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check("result",  32'(result), 32'(e[EW-1 -: W+1]));
        check("neg",     32'(neg),    32'(e[4*D]));
        check("bcd",     32'(bcd),    32'(e[4*D-1:0]));
        check("latency", 32'(cyc - l), 32'(W + 2));
      end
    end
  end

  // driver tasks
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 32'(1), 32'(0));
  endtask

  task automatic issue(input logic m, input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
    wait_idle();
    start = 1'b1;
    mode  = m;
    a     = x;
    b     = y;
    exp_q.push_back(model(m, x, y));
    lat_q.push_back(cyc + 1);
    done_exp++;
    if (!hold) begin
      @(negedge clk);
      check("busy_calc", 32'(busy), 32'(1));
      start = 1'b0;
      mode  = 1'($urandom);
      a     = W'($urandom);
      b     = W'($urandom);
    end else begin
      repeat (W + 2) begin
        @(negedge clk);
        mode = 1'($urandom);
        a    = W'($urandom);
        b    = W'($urandom);
      end
      @(negedge clk);
      check("hold_done", 32'(done), 32'(1));
      start = 1'b0;
    end
  endtask

  task automatic run4(input logic m, input logic [3:0] x, input logic [3:0] y,
                      input logic [4:0] er, input logic [7:0] eb, input logic en);
    int c0, n;
    @(negedge clk);
    start4 = 1'b1;
    mode4  = m;
    a4     = x;
    b4     = y;
    c0     = cyc + 1;
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("w4_timeout", 32'(1), 32'(0));
    else begin
      check("w4_latency", 32'(cyc - c0), 32'(6));
      check("w4_result",  32'(result4),  32'(er));
      check("w4_bcd",     32'(bcd4),     32'(eb));
      check("w4_neg",     32'(neg4),     32'(en));
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    start  = 1'b0; mode  = 1'b0; a  = '0; b  = '0;
    start4 = 1'b0; mode4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   32'(busy),      32'(0));
    check("rst_done",   32'(done),      32'(0));
    check("rst_result", 32'(result),    32'(0));
    check("rst_bcd",    32'(bcd),       32'(0));
    check("rst_state",  32'(state_dbg), 32'(0));
    rst_n = 1'b1;

    issue(1'b0, 8'd200, 8'd100, 1'b0);
    issue(1'b0, 8'd255, 8'd255, 1'b0);
    issue(1'b1, 8'd5,   8'd3,   1'b0);
    issue(1'b1, 8'd3,   8'd5,   1'b0);
    issue(1'b1, 8'd0,   8'd255, 1'b0);
    issue(1'b0, 8'd0,   8'd0,   1'b0);
    issue(1'b1, 8'd77,  8'd77,  1'b0);
    issue(1'b0, 8'd123, 8'd45,  1'b1);
    issue(1'b1, 8'd9,   8'd200, 1'b1);

    // Abort a conversion in flight, then confirm a fresh start works.
    wait_idle();
    start = 1'b1; mode = 1'b0; a = 8'd99; b = 8'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_busy",   32'(busy),      32'(0));
    check("abort_done",   32'(done),      32'(0));
    check("abort_result", 32'(result),    32'(0));
    check("abort_neg",    32'(neg),       32'(0));
    check("abort_bcd",    32'(bcd),       32'(0));
    check("abort_state",  32'(state_dbg), 32'(0));

    for (int i = 0; i < 30; i++)
      issue(1'($urandom), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), (i % 7) == 3);

    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'(0));
    repeat (3) @(negedge clk);
    check("done_count", 32'(done_seen), 32'(done_exp));

    run4(1'b1, 4'd0,  4'd0,  5'h00, 8'h00, 1'b0);
    run4(1'b0, 4'd15, 4'd15, 5'h1E, 8'h30, 1'b0);
`ifdef SIGNED_MAG_EN
    run4(1'b1, 4'd3,  4'd5,  5'h1E, 8'h02, 1'b1);
`else
    run4(1'b1, 4'd3,  4'd5,  5'h1E, 8'h14, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
